// File: rtl/tree_ensemble_scheduler.sv
// Launches every decision-function engine for one sample, gathers done/score pairs and
// returns the signed score sum (with timeout and partial-result reporting) on a valid/ready port.
module tree_ensemble_scheduler #(
  parameter int unsigned N_TREES = 8,
  parameter int unsigned SCORE_W = 18,
  parameter int unsigned SUM_W   = 21,
  parameter int unsigned TMO_W   = 16
) (
  input  logic                       ap_clk,
  input  logic                       ap_rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [N_TREES-1:0]         tree_start,
  input  logic [N_TREES-1:0]         tree_ready,
  input  logic [N_TREES-1:0]         tree_done,
  input  logic [N_TREES*SCORE_W-1:0] tree_score,
  input  logic [TMO_W-1:0]           tmo_limit,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [SUM_W-1:0]           out_sum,
  output logic                       out_err,
  output logic [N_TREES-1:0]         out_done_mask,
  output logic [31:0]                sample_cnt
);

  typedef enum logic [1:0] {StIdle, StRun, StOut} state_e;

  state_e             state_q, state_d;
  logic [N_TREES-1:0] launched_q, launched_d;
  logic [N_TREES-1:0] done_q, done_d;
  logic [N_TREES-1:0] take;
  logic [SUM_W-1:0]   sum_q, sum_d, add;
  logic [TMO_W-1:0]   timer_q, timer_d;
  logic               err_q, err_d;
  logic [31:0]        cnt_q, cnt_d;

  // A done counts if the engine was launched earlier or is being launched on this same edge.
  always_comb begin
    tree_start = '0;
    take       = '0;
    if (state_q == StRun) begin
      tree_start = ~launched_q;
      take       = tree_done & ~done_q & (launched_q | (tree_start & tree_ready));
    end
  end

  always_comb begin
    logic [SCORE_W-1:0] s;
    add = '0;
    s   = '0;
    for (int i = 0; i < int'(N_TREES); i++) begin
      s = tree_score[i*SCORE_W +: SCORE_W];
      if (take[i]) add = add + SUM_W'(signed'(s));
    end
  end

  always_comb begin
    state_d    = state_q;
    launched_d = launched_q;
    done_d     = done_q;
    sum_d      = sum_q;
    timer_d    = timer_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    in_ready   = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          launched_d = '0;
          done_d     = '0;
          sum_d      = '0;
          timer_d    = '0;
          err_d      = 1'b0;
          state_d    = StRun;
        end
      end
      StRun: begin
        launched_d = launched_q | (tree_start & tree_ready);
        done_d     = done_q | take;
        sum_d      = sum_q + add;
        if (timer_q != '1) timer_d = timer_q + TMO_W'(1);
        // Completion is tested first so a simultaneous timeout still reports a clean result.
        if (&done_d) begin
          err_d   = 1'b0;
          state_d = StOut;
        end else if ((tmo_limit != '0) && (timer_q == tmo_limit - TMO_W'(1))) begin
          err_d   = 1'b1;
          state_d = StOut;
        end
      end
      StOut: begin
        if (out_ready) begin
          cnt_d   = cnt_q + 32'd1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q    <= StIdle;
      launched_q <= '0;
      done_q     <= '0;
      sum_q      <= '0;
      timer_q    <= '0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      launched_q <= launched_d;
      done_q     <= done_d;
      sum_q      <= sum_d;
      timer_q    <= timer_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out_valid     = (state_q == StOut);
  assign out_sum       = sum_q;
  assign out_err       = err_q;
  assign out_done_mask = done_q;
  assign sample_cnt    = cnt_q;

endmodule

// File: tb/tb_tree_ensemble_scheduler.sv
// Bench for tree_ensemble_scheduler: behavioural engines driven from per-sample plans, results
// compared against a cycle-count/arithmetic model of the scheduling rules.
module tb_tree_ensemble_scheduler;
  localparam int N  = 8;
  localparam int SW = 18;
  localparam int UW = 21;
  localparam int TW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0, in_ready;
  logic [N-1:0]  tree_start, out_done_mask;
  logic [N-1:0]  tree_ready = '0, tree_done = '0;
  logic [N*SW-1:0] tree_score = '0;
  logic [TW-1:0] tmo_limit = '0;
  logic          out_valid, out_ready = 1'b0, out_err;
  logic [UW-1:0] out_sum;
  logic [31:0]   sample_cnt;

  int checks = 0, errors = 0;

  // Per-sample engine plan: ready delay, done delay after launch, score, spurious dones.
  int p_rd[N], p_dd[N], p_sc[N];
  bit p_se[N], p_sr[N];
  int p_tmo, p_ord;

  logic [UW-1:0] e_sum;
  logic          e_err;
  logic [N-1:0]  e_mask;
  int            e_lat, e_hi[N], exp_cnt;

  logic [UW-1:0] o_sum;
  logic          o_err, o_post_valid, o_post_inready;
  logic [N-1:0]  o_mask;
  int            o_lat, o_hi[N], o_run_inready, o_changed, o_hold_inready;
  logic [31:0]   o_cnt;

  tree_ensemble_scheduler #(.N_TREES(N), .SCORE_W(SW), .SUM_W(UW), .TMO_W(TW)) dut (
    .ap_clk(clk), .ap_rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .tree_start(tree_start), .tree_ready(tree_ready), .tree_done(tree_done),
    .tree_score(tree_score), .tmo_limit(tmo_limit), .out_valid(out_valid),
    .out_ready(out_ready), .out_sum(out_sum), .out_err(out_err),
    .out_done_mask(out_done_mask), .sample_cnt(sample_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  function automatic int rnd_score();
    return int'($urandom_range(0, (1 << SW) - 1)) - (1 << (SW - 1));
  endfunction

  task automatic clear_plan();
    for (int i = 0; i < N; i++) begin
      p_rd[i] = 0; p_dd[i] = 0; p_sc[i] = rnd_score(); p_se[i] = 0; p_sr[i] = 0;
    end
    p_tmo = 0;
    p_ord = 0;
  endtask

  // Engine i sees start from RUN cycle 1, answers ready in cycle 1+rd and done dd cycles later.
  task automatic model();
    int dc, last, ex;
    longint s;
    last = 0;
    for (int i = 0; i < N; i++) begin
      dc = 1 + p_rd[i] + p_dd[i];
      if (dc > last) last = dc;
    end
    if (p_tmo == 0 || last <= p_tmo) begin ex = last; e_err = 1'b0; end
    else begin ex = p_tmo; e_err = 1'b1; end
    s = 0;
    e_mask = '0;
    for (int i = 0; i < N; i++) begin
      dc = 1 + p_rd[i] + p_dd[i];
      if (dc <= ex) begin s += longint'(p_sc[i]); e_mask[i] = 1'b1; end
      e_hi[i] = (1 + p_rd[i] < ex) ? 1 + p_rd[i] : ex;
    end
    e_sum = s[UW-1:0];
    e_lat = ex + 1;
    exp_cnt++;
  endtask

  // Called at a negedge; returns at a negedge with the result consumed.
  task automatic run_sample();
    int w, cyc, dc;
    logic [UW-1:0] h_sum;
    logic          h_err;
    logic [N-1:0]  h_mask;
    tmo_limit = TW'(p_tmo);
    w = 0;
    while (!in_ready && w < 50) begin @(negedge clk); w++; end
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 1; o_run_inready = 0; o_changed = 0; o_hold_inready = 0;
    for (int i = 0; i < N; i++) o_hi[i] = 0;
    while (!out_valid && cyc <= 400) begin
      for (int i = 0; i < N; i++) if (tree_start[i]) o_hi[i]++;
      if (in_ready) o_run_inready++;
      for (int i = 0; i < N; i++) begin
        dc = 1 + p_rd[i] + p_dd[i];
        tree_ready[i] = (cyc == 1 + p_rd[i]);
        tree_done[i]  = (cyc == dc) || (p_se[i] && p_rd[i] >= 1 && cyc == 1) ||
                        (p_sr[i] && cyc == dc + 1);
        tree_score[i*SW +: SW] = (cyc == dc) ? SW'(p_sc[i]) : SW'($urandom);
      end
      @(negedge clk);
      cyc++;
    end
    tree_ready = '0;
    tree_done  = '0;
    o_lat = cyc; o_sum = out_sum; o_err = out_err; o_mask = out_done_mask;
    h_sum = out_sum; h_err = out_err; h_mask = out_done_mask;
    for (int k = 0; k < p_ord; k++) begin
      if (k == 0) begin
        tree_done = '1;
        for (int i = 0; i < N; i++) tree_score[i*SW +: SW] = SW'($urandom);
      end
      @(negedge clk);
      tree_done = '0;
      if (!out_valid || out_sum !== h_sum || out_err !== h_err || out_done_mask !== h_mask)
        o_changed++;
      if (in_ready) o_hold_inready++;
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    o_post_valid = out_valid; o_post_inready = in_ready; o_cnt = sample_cnt;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++;
      $display("FAIL reset in_ready: got %b want 1", in_ready); end
    checks++; if (tree_start !== '0) begin errors++;
      $display("FAIL reset tree_start: got %h want 0", tree_start); end
    checks++; if (out_valid !== 1'b0 || out_err !== 1'b0) begin errors++;
      $display("FAIL reset valid/err: got %b%b want 00", out_valid, out_err); end
    checks++; if (out_sum !== '0 || out_done_mask !== '0 || sample_cnt !== '0) begin errors++;
      $display("FAIL reset sum/mask/cnt: got %h %h %h want 0", out_sum, out_done_mask,
               sample_cnt); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_staggered();
    clear_plan();
    for (int i = 0; i < N; i++) begin p_dd[i] = i; p_sc[i] = i + 1; end
    model();
    run_sample();
    checks++; if (o_sum !== UW'(36) || o_sum !== e_sum) begin errors++;
      $display("FAIL t1 sum: got %0d want 36", $signed(o_sum)); end
    checks++; if (o_err !== 1'b0 || o_mask !== 8'hFF) begin errors++;
      $display("FAIL t1 err/mask: got %b %h want 0 ff", o_err, o_mask); end
    checks++; if (o_lat !== e_lat) begin errors++;
      $display("FAIL t1 latency: got %0d want %0d", o_lat, e_lat); end
    for (int i = 0; i < N; i++) begin
      checks++; if (o_hi[i] !== e_hi[i]) begin errors++;
        $display("FAIL t1 start_cycles[%0d]: got %0d want %0d", i, o_hi[i], e_hi[i]); end
    end
    checks++; if (o_run_inready !== 0) begin errors++;
      $display("FAIL t1 in_ready_in_run: got %0d want 0", o_run_inready); end
    checks++; if (o_post_valid !== 1'b0 || o_post_inready !== 1'b1 || o_cnt !== 32'(exp_cnt))
      begin errors++; $display("FAIL t1 handshake: got %b %b %0d want 0 1 %0d",
                               o_post_valid, o_post_inready, o_cnt, exp_cnt); end
  endtask

  task automatic test_simultaneous();
    clear_plan();
    for (int i = 0; i < N; i++) begin p_dd[i] = 2; p_sc[i] = (i % 2 == 0) ? -5 : 3; end
    model();
    run_sample();
    checks++; if (o_sum !== e_sum || $signed(o_sum) !== -21'sd8) begin errors++;
      $display("FAIL t2 sum: got %0d want -8", $signed(o_sum)); end
    checks++; if (o_mask !== 8'hFF || o_err !== 1'b0) begin errors++;
      $display("FAIL t2 mask/err: got %h %b want ff 0", o_mask, o_err); end
    checks++; if (o_lat !== e_lat) begin errors++;
      $display("FAIL t2 latency: got %0d want %0d", o_lat, e_lat); end
    checks++; if (o_cnt !== 32'(exp_cnt)) begin errors++;
      $display("FAIL t2 sample_cnt: got %0d want %0d", o_cnt, exp_cnt); end
  endtask

  task automatic test_ready_stall();
    clear_plan();
    for (int i = 0; i < N; i++) p_dd[i] = 1;
    p_rd[3] = 9;
    p_se[3] = 1'b1;
    model();
    run_sample();
    checks++; if (o_hi[3] !== 10) begin errors++;
      $display("FAIL t3 start3_cycles: got %0d want 10", o_hi[3]); end
    for (int i = 0; i < N; i++) begin
      checks++; if (o_hi[i] !== e_hi[i]) begin errors++;
        $display("FAIL t3 start_cycles[%0d]: got %0d want %0d", i, o_hi[i], e_hi[i]); end
    end
    checks++; if (o_sum !== e_sum || o_err !== 1'b0 || o_mask !== 8'hFF) begin errors++;
      $display("FAIL t3 result: got %h %b %h want %h 0 ff", o_sum, o_err, o_mask, e_sum); end
    checks++; if (o_lat !== e_lat) begin errors++;
      $display("FAIL t3 latency: got %0d want %0d", o_lat, e_lat); end
  endtask

  task automatic test_timeout();
    clear_plan();
    for (int i = 0; i < N; i++) begin p_dd[i] = i; p_sc[i] = 2; end
    p_dd[5] = 1000;
    p_tmo = 20;
    p_ord = 3;
    model();
    run_sample();
    checks++; if (o_err !== 1'b1 || o_lat !== 21 || o_lat !== e_lat) begin errors++;
      $display("FAIL t4 err/latency: got %b %0d want 1 21", o_err, o_lat); end
    checks++; if (o_sum !== UW'(14) || o_mask !== 8'hDF || o_mask !== e_mask) begin errors++;
      $display("FAIL t4 sum/mask: got %0d %h want 14 df", $signed(o_sum), o_mask); end
    checks++; if (o_changed !== 0 || o_hold_inready !== 0) begin errors++;
      $display("FAIL t4 late_done_hold: got %0d %0d want 0 0", o_changed, o_hold_inready); end
    checks++; if (o_cnt !== 32'(exp_cnt)) begin errors++;
      $display("FAIL t4 sample_cnt: got %0d want %0d", o_cnt, exp_cnt); end
  endtask

  task automatic test_back_to_back();
    for (int s = 0; s < 4; s++) begin
      clear_plan();
      for (int i = 0; i < N; i++) p_dd[i] = int'($urandom_range(0, 3));
      p_ord = (s == 0) ? 5 : 0;
      model();
      run_sample();
      checks++; if (o_sum !== e_sum || o_mask !== e_mask || o_err !== e_err) begin errors++;
        $display("FAIL t5 result[%0d]: got %h %h %b want %h %h %b", s, o_sum, o_mask, o_err,
                 e_sum, e_mask, e_err); end
      checks++; if (o_changed !== 0 || o_hold_inready !== 0) begin errors++;
        $display("FAIL t5 hold[%0d]: got %0d %0d want 0 0", s, o_changed, o_hold_inready); end
      checks++; if (o_cnt !== 32'(exp_cnt) || o_post_inready !== 1'b1) begin errors++;
        $display("FAIL t5 cnt[%0d]: got %0d %b want %0d 1", s, o_cnt, o_post_inready,
                 exp_cnt); end
    end
  endtask

  task automatic test_reset_mid_run();
    int part;
    clear_plan();
    tmo_limit = '0;
    part = 0;
    for (int i = 0; i < 4; i++) part += p_sc[i];
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      tree_ready = (c == 1) ? '1 : '0;
      tree_done  = '0;
      if (c <= 4) begin
        tree_done[c-1] = 1'b1;
        tree_score[(c-1)*SW +: SW] = SW'(p_sc[c-1]);
      end
      @(negedge clk);
    end
    tree_ready = '0;
    tree_done  = '0;
    checks++; if (out_done_mask !== 8'h0F || out_sum !== UW'(part)) begin errors++;
      $display("FAIL t6 partial: got %h %h want 0f %h", out_done_mask, out_sum, UW'(part)); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (tree_start !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++;
      $display("FAIL t6 reset ctl: got %h %b %b want 0 0 1", tree_start, out_valid, in_ready);
    end
    checks++; if (out_sum !== '0 || out_done_mask !== '0 || sample_cnt !== '0 || out_err !== 0)
      begin errors++; $display("FAIL t6 reset data: got %h %h %0d %b want 0 0 0 0", out_sum,
                               out_done_mask, sample_cnt, out_err); end
    rst = 1'b0;
    exp_cnt = 0;
    tree_done = '1;
    @(negedge clk);
    tree_done = '0;
    checks++; if (out_done_mask !== '0 || out_sum !== '0) begin errors++;
      $display("FAIL t6 late_done: got %h %h want 0 0", out_done_mask, out_sum); end
    clear_plan();
    for (int i = 0; i < N; i++) p_dd[i] = int'($urandom_range(0, 4));
    model();
    run_sample();
    checks++; if (o_sum !== e_sum || o_mask !== 8'hFF || o_err !== 1'b0) begin errors++;
      $display("FAIL t6 after_reset: got %h %h %b want %h ff 0", o_sum, o_mask, o_err, e_sum);
    end
    checks++; if (o_cnt !== 32'd1) begin errors++;
      $display("FAIL t6 sample_cnt: got %0d want 1", o_cnt); end
  endtask

  task automatic test_random();
    for (int s = 0; s < 25; s++) begin
      clear_plan();
      if (s == 0) begin
        // completion on the very edge the timeout would fire
        for (int i = 0; i < N; i++) p_dd[i] = i;
        p_tmo = 8;
      end else begin
        p_tmo = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(3, 15));
        p_ord = int'($urandom_range(0, 3));
        for (int i = 0; i < N; i++) begin
          p_rd[i] = int'($urandom_range(0, 4));
          p_dd[i] = int'($urandom_range(0, 6));
          p_se[i] = ($urandom_range(0, 3) == 0);
          p_sr[i] = ($urandom_range(0, 3) == 0);
          if (p_tmo != 0 && $urandom_range(0, 4) == 0) p_dd[i] = 1000;
        end
      end
      model();
      run_sample();
      checks++; if (o_sum !== e_sum || o_mask !== e_mask || o_err !== e_err) begin errors++;
        $display("FAIL rnd result[%0d]: got %h %h %b want %h %h %b", s, o_sum, o_mask, o_err,
                 e_sum, e_mask, e_err); end
      checks++; if (o_lat !== e_lat) begin errors++;
        $display("FAIL rnd latency[%0d]: got %0d want %0d", s, o_lat, e_lat); end
      for (int i = 0; i < N; i++) begin
        checks++; if (o_hi[i] !== e_hi[i]) begin errors++;
          $display("FAIL rnd start[%0d][%0d]: got %0d want %0d", s, i, o_hi[i], e_hi[i]); end
      end
      checks++; if (o_changed !== 0 || o_hold_inready !== 0 || o_run_inready !== 0) begin
        errors++; $display("FAIL rnd stability[%0d]: got %0d %0d %0d want 0 0 0", s,
                           o_changed, o_hold_inready, o_run_inready); end
      checks++; if (o_cnt !== 32'(exp_cnt) || o_post_valid !== 1'b0) begin errors++;
        $display("FAIL rnd cnt[%0d]: got %0d %b want %0d 0", s, o_cnt, o_post_valid,
                 exp_cnt); end
    end
  endtask

  initial begin
    exp_cnt = 0;
    test_reset();
    test_staggered();
    test_simultaneous();
    test_ready_stall();
    test_timeout();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
